// File: rtl/vga_rx_monitor.sv
// Receive-side VGA stream monitor: recovers line/frame position from the syncs,
// checks timing, tracks lock, captures one pixel and sums RGB over each frame.
module vga_rx_monitor #(
  parameter int DATA_W   = 24,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              pix_en,
  input  logic              vga_hs,
  input  logic              vga_vs,
  input  logic              vga_blank_n,
  input  logic [DATA_W-1:0] vga_rgb,
  input  logic [9:0]        sample_x,
  input  logic [8:0]        sample_y,
  output logic [DATA_W-1:0] sample_rgb,
  output logic              sample_valid,
  output logic              frame_done,
  output logic [DATA_W-1:0] frame_sum,
  output logic [15:0]       frame_count,
  output logic              locked,
  output logic              err_h,
  output logic              err_v,
  input  logic              err_clr
);

  typedef enum logic [1:0] {SEARCH, MEASURE, GOOD1, LOCKED} state_t;

  state_t            state_q, state_d;
  logic              hs_p0, vs_p0;
  logic [9:0]        pcnt, acnt, lcnt, alcnt;
  logic              line_seen, frame_started, frame_bad;
  logic [DATA_W-1:0] run_sum;
  logic [9:0]        sx_q;
  logic [8:0]        sy_q;

  logic              hs_fall, vs_fall, frame_end;
  logic              err_h_evt, err_v_evt, cap_hit;
  logic [9:0]        lcnt_end, alcnt_end;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Edge detection and the line-end / frame-end decisions for this pixel.
  // lcnt_end/alcnt_end fold in a coincident line end so the frame check sees it.
  always_comb begin
    hs_fall   = pix_en & hs_p0 & ~vga_hs;
    vs_fall   = pix_en & vs_p0 & ~vga_vs;
    frame_end = vs_fall & frame_started;
    lcnt_end  = hs_fall ? sat_inc(lcnt) : lcnt;
    alcnt_end = (hs_fall && acnt != 10'd0) ? sat_inc(alcnt) : alcnt;
    err_h_evt = hs_fall & line_seen &
                ((({1'b0, pcnt} + 11'd1) != 11'(H_TOTAL)) |
                 ((acnt != 10'd0) & (acnt != 10'(H_ACTIVE))));
    err_v_evt = frame_end & ((lcnt_end != 10'(V_TOTAL)) | (alcnt_end != 10'(V_ACTIVE)));
    cap_hit   = pix_en & vga_blank_n & frame_started &
                (acnt == sx_q) & (alcnt == {1'b0, sy_q});
  end

  // Stage p0: stream position counters and running checksum.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hs_p0         <= 1'b0;
      vs_p0         <= 1'b0;
      pcnt          <= '0;
      acnt          <= '0;
      lcnt          <= '0;
      alcnt         <= '0;
      line_seen     <= 1'b0;
      frame_started <= 1'b0;
      frame_bad     <= 1'b0;
      run_sum       <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
    end else if (pix_en) begin
      hs_p0 <= vga_hs;
      vs_p0 <= vga_vs;
      if (hs_fall) begin
        pcnt      <= '0;
        acnt      <= {9'd0, vga_blank_n};
        line_seen <= 1'b1;
        lcnt      <= lcnt_end;
        alcnt     <= alcnt_end;
      end else begin
        pcnt <= sat_inc(pcnt);
        if (vga_blank_n) acnt <= sat_inc(acnt);
      end
      if (vs_fall) begin
        // A coincident HS fall opens the first line of the new frame.
        lcnt          <= '0;
        alcnt         <= '0;
        line_seen     <= hs_fall;
        run_sum       <= vga_blank_n ? vga_rgb : '0;
        sx_q          <= sample_x;
        sy_q          <= sample_y;
        frame_started <= 1'b1;
        frame_bad     <= 1'b0;
      end else begin
        if (vga_blank_n) run_sum <= run_sum + vga_rgb;
        if (err_h_evt) frame_bad <= 1'b1;
      end
    end
  end

  // Stage p1: registered results, pulses and sticky flags.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      frame_done   <= 1'b0;
      frame_sum    <= '0;
      frame_count  <= '0;
      sample_valid <= 1'b0;
      sample_rgb   <= '0;
      err_h        <= 1'b0;
      err_v        <= 1'b0;
    end else begin
      frame_done   <= frame_end;
      sample_valid <= cap_hit;
      if (frame_end) begin
        frame_sum   <= run_sum;
        frame_count <= frame_count + 16'd1;
      end
      if (cap_hit) sample_rgb <= vga_rgb;
      if (err_h_evt)    err_h <= 1'b1;
      else if (err_clr) err_h <= 1'b0;
      if (err_v_evt)    err_v <= 1'b1;
      else if (err_clr) err_v <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // A frame only advances lock if no line error was seen anywhere inside it.
  always_comb begin
    state_d = state_q;
    if (err_h_evt || err_v_evt) begin
      state_d = MEASURE;
    end else if (vs_fall) begin
      case (state_q)
        SEARCH:  state_d = MEASURE;
        MEASURE: if (frame_started && !frame_bad) state_d = GOOD1;
        GOOD1:   if (!frame_bad) state_d = LOCKED;
        default: state_d = state_q;
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor on a reduced 12x7 raster (8x4 active).
module tb_vga_rx_monitor;
  localparam int HA = 8, HT = 12, VA = 4, VT = 7, HSF = 9, HSW = 2, VSL = 5;

  logic        HCLK = 1'b0, HRESET = 1'b1, pix_en = 1'b0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0, err_clr = 1'b0;
  logic [23:0] vga_rgb = '0;
  logic [9:0]  sample_x = '0;
  logic [8:0]  sample_y = '0;
  logic [23:0] sample_rgb, frame_sum;
  logic        sample_valid, frame_done, locked, err_h, err_v;
  logic [15:0] frame_count;

  always #5 HCLK = ~HCLK;

  vga_rx_monitor #(.DATA_W(24), .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .pix_en(pix_en), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_rgb(vga_rgb), .sample_x(sample_x), .sample_y(sample_y),
    .sample_rgb(sample_rgb), .sample_valid(sample_valid), .frame_done(frame_done),
    .frame_sum(frame_sum), .frame_count(frame_count), .locked(locked), .err_h(err_h),
    .err_v(err_v), .err_clr(err_clr));

  typedef struct packed {
    logic [23:0] sum;
    logic [15:0] cnt;
    logic        lk;
    logic        eh;
    logic        ev;
  } fexp_t;

  fexp_t       fq[$];
  logic [23:0] cq[$];
  int n_cmp = 0, n_bad = 0;
  int fd_pushed = 0, fd_seen = 0, cap_pushed = 0, cap_seen = 0;
  bit tb_started = 0, tb_prev_vs = 0;
  int lat_x = 0, lat_y = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-computed 32-pixel frame sums: 32*1, 32*0xFFFFFF mod 2^24, ramp {x,y}.
  function automatic logic [23:0] pat_sum(input int pat);
    case (pat)
      0:       return 24'h000020;
      1:       return 24'hFFFFE0;
      default: return 24'h070030;
    endcase
  endfunction

  function automatic logic [23:0] pat_rgb(input int pat, input int x, input int y);
    case (pat)
      0:       return 24'h000001;
      1:       return 24'hFFFFFF;
      default: return {12'(x), 12'(y)};
    endcase
  endfunction

  // Output monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge HCLK) begin
    fexp_t       e;
    logic [23:0] c;
    if (!HRESET && frame_done) begin
      fd_seen++;
      if (fq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL frame_done: unexpected pulse with count 0x%0h, expected none", frame_count);
      end else begin
        e = fq.pop_front();
        chk("frame_sum", frame_sum, e.sum);
        chk("frame_count", frame_count, e.cnt);
        chk("locked", locked, e.lk);
        chk("err_h", err_h, e.eh);
        chk("err_v", err_v, e.ev);
      end
    end
    if (!HRESET && sample_valid) begin
      cap_seen++;
      if (cq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sample_valid: unexpected capture 0x%0h, expected none", sample_rgb);
      end else begin
        c = cq.pop_front();
        chk("sample_rgb", sample_rgb, c);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_sample_rgb"}, sample_rgb, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_sum"}, frame_sum, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_h"}, err_h, 0);
    chk({tag, "_err_v"}, err_v, 0);
  endtask

  task automatic mid_reset();
    @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1 check_zero("midreset");
    tb_started = 0;
    tb_prev_vs = 0;
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge HCLK); err_clr = 1'b1;
    @(negedge HCLK); err_clr = 1'b0;
    chk("err_h_after_clr", err_h, 0);
    chk("err_v_after_clr", err_v, 0);
  endtask

  // One raster frame; expectations apply to the frame that ends at this frame's VS fall.
  task automatic gen_frame(input int nlines, input int long_l, input bit coinc, input int pat,
                           input logic [15:0] e_cnt, input logic e_lk, input logic e_eh,
                           input logic e_ev, input int rst_l = -1, input int rst_p = -1);
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < HT + ((l == long_l) ? 1 : 0); p++) begin
        int          pp;
        logic        h, v, act;
        logic [23:0] rgb;
        if (l == rst_l && p == rst_p) mid_reset();
        pp  = (p >= HT) ? HT - 1 : p;
        act = (l < VA) && (pp < HA);
        h   = !(pp >= HSF && pp < HSF + HSW);
        v   = coinc ? !((l == VSL - 1 && pp >= HSF) || (l == VSL && pp < HSF)) : (l != VSL);
        rgb = act ? pat_rgb(pat, pp, l) : 24'hABCDEF;
        if (!v && tb_prev_vs) begin
          if (tb_started) begin
            fq.push_back('{sum: pat_sum(pat), cnt: e_cnt, lk: e_lk, eh: e_eh, ev: e_ev});
            fd_pushed++;
          end
          tb_started = 1;
          lat_x = int'(sample_x);
          lat_y = int'(sample_y);
        end
        tb_prev_vs = v;
        if (act && tb_started && l == lat_y && pp == lat_x) begin
          cq.push_back(rgb);
          cap_pushed++;
        end
        @(negedge HCLK);
        vga_hs = h; vga_vs = v; vga_blank_n = act; vga_rgb = rgb; pix_en = 1'b1;
        @(negedge HCLK);
        pix_en = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge HCLK);
    check_zero("reset");
    HRESET = 1'b0;
    sample_x = 10'd7;
    sample_y = 9'd3;
    //        lines long coinc pat  cnt lk eh ev
    gen_frame(7,    -1,  0,    0,   0,  0, 0, 0);
    gen_frame(7,    -1,  0,    0,   1,  0, 0, 0);
    gen_frame(7,    -1,  0,    0,   2,  1, 0, 0);
    gen_frame(7,    -1,  0,    1,   3,  1, 0, 0);
    gen_frame(7,    -1,  0,    2,   4,  1, 0, 0);
    gen_frame(7,     1,  0,    2,   5,  0, 1, 0);
    gen_frame(7,    -1,  0,    2,   6,  0, 1, 0);
    gen_frame(7,    -1,  0,    2,   7,  1, 1, 0);
    chk("err_h_sticky", err_h, 1);
    pulse_clr();
    gen_frame(6,    -1,  0,    2,   8,  1, 0, 0);
    gen_frame(7,    -1,  0,    2,   9,  0, 0, 1);
    chk("err_v_sticky", err_v, 1);
    pulse_clr();
    gen_frame(7,    -1,  1,    2,  10,  0, 0, 0);
    gen_frame(7,    -1,  1,    2,  11,  1, 0, 0);
    gen_frame(7,    -1,  0,    2,  12,  1, 0, 0);
    gen_frame(7,    -1,  0,    2,   0,  0, 0, 0, 1, 5);
    gen_frame(7,    -1,  0,    2,   1,  0, 0, 0);
    repeat (4) @(negedge HCLK);
    chk("frame_done_total", fd_seen, fd_pushed);
    chk("capture_total", cap_seen, cap_pushed);
    chk("frame_queue_left", fq.size(), 0);
    chk("capture_queue_left", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
